// File: rtl/sobel_stream_if.sv
// Pixel-in / edge-out stream bundle for sobel_stream.
// The slave side is the edge engine. The master side is whoever feeds pixels and drains results.
interface sobel_stream_if #(
  parameter int PIX_W = 4,
  parameter int OUT_W = PIX_W + 3
);
  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_pixel, out_valid
  );

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_pixel, out_valid
  );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge engine: two line buffers feed a sliding window.
// Each advance step emits the result centred IMG_W+1 pixels behind the newest input.
module sobel_stream #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 4,
  parameter int OUT_W = PIX_W + 3,
  parameter int MODE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic [PIX_W+2:0] i_thresh,
  sobel_stream_if.slave    s_if,
  output logic             o_busy,
  output logic             o_done
);
  localparam int PS_W    = PIX_W + 2;
  localparam int SUM_W   = PIX_W + 3;
  localparam int HW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int VW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FLUSH_N = IMG_W + 1;
  localparam int FW      = $clog2(IMG_W + 2);
  localparam longint SAT_MAX = (longint'(1) << OUT_W) - 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           r_state;
  logic [HW-1:0]    r_hIn;
  logic [VW-1:0]    r_vIn;
  logic [HW-1:0]    r_hOut;
  logic [VW-1:0]    r_vOut;
  logic [FW-1:0]    r_flushCnt;
  logic [SUM_W-1:0] r_thresh;
  logic [OUT_W-1:0] r_outPixel;
  logic             r_outValid;
  logic             r_busy;
  logic             r_done;

  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  // Window columns l and c; the right column is the live line-buffer/pixel column.
  logic [PIX_W-1:0] r_win [3][2];

  logic             w_outFree;
  logic             w_inReady;
  logic             w_flushStep;
  logic             w_adv;
  logic             w_emit;
  logic             w_border;
  logic [PIX_W-1:0] w_pix;
  logic [PIX_W-1:0] w_col [3];
  logic [PS_W-1:0]  w_gxPos, w_gxNeg, w_gyPos, w_gyNeg;
  logic [PS_W-1:0]  w_absX, w_absY;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_sel;
  logic [OUT_W-1:0] w_res;

  function automatic logic [PS_W-1:0] ext1(input logic [PIX_W-1:0] p);
    return {2'b00, p};
  endfunction

  function automatic logic [PS_W-1:0] ext2(input logic [PIX_W-1:0] p);
    return {1'b0, p, 1'b0};
  endfunction

  assign w_outFree   = !r_outValid || s_if.out_ready;
  assign w_inReady   = ((r_state == S_FILL) || (r_state == S_RUN)) && w_outFree;
  assign w_flushStep = (r_state == S_FLUSH) && (r_flushCnt != FW'(FLUSH_N)) && w_outFree;
  assign w_adv       = (w_inReady && s_if.in_valid) || w_flushStep;
  assign w_emit      = w_adv && (r_state != S_FILL);
  assign w_pix       = (r_state == S_FLUSH) ? '0 : s_if.in_pixel;
  assign w_border    = (r_hOut == '0) || (r_hOut == HW'(IMG_W - 1)) ||
                       (r_vOut == '0) || (r_vOut == VW'(IMG_H - 1));

  always_comb begin
    w_col[0] = r_lb1[r_hIn];
    w_col[1] = r_lb0[r_hIn];
    w_col[2] = w_pix;
  end

  // Kernel on the post-shift window so the result registers on the same step.
  always_comb begin
    w_gxPos = ext1(w_col[0]) + ext2(w_col[1]) + ext1(w_col[2]);
    w_gxNeg = ext1(r_win[0][0]) + ext2(r_win[1][0]) + ext1(r_win[2][0]);
    w_gyPos = ext1(r_win[2][0]) + ext2(r_win[2][1]) + ext1(w_col[2]);
    w_gyNeg = ext1(r_win[0][0]) + ext2(r_win[0][1]) + ext1(w_col[0]);
    w_absX  = (w_gxPos >= w_gxNeg) ? (w_gxPos - w_gxNeg) : (w_gxNeg - w_gxPos);
    w_absY  = (w_gyPos >= w_gyNeg) ? (w_gyPos - w_gyNeg) : (w_gyNeg - w_gyPos);
    w_sum   = {1'b0, w_absX} + {1'b0, w_absY};
  end

  always_comb begin
    w_sel = w_sum;
    w_res = '0;
    if (MODE == 1) w_sel = {1'b0, w_absX};
    else if (MODE == 2) w_sel = {1'b0, w_absY};
    if (MODE == 3) begin
      w_res = (w_sum > r_thresh) ? '1 : '0;
    end else if (longint'(w_sel) > SAT_MAX) begin
      w_res = '1;
    end else begin
      w_res = OUT_W'(w_sel);
    end
  end

  // Line buffers and window carry no reset; stale contents only reach border outputs.
  always_ff @(posedge clock) begin
    if (w_adv) begin
      r_lb0[r_hIn] <= w_pix;
      r_lb1[r_hIn] <= r_lb0[r_hIn];
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= w_col[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hIn      <= '0;
      r_vIn      <= '0;
      r_hOut     <= '0;
      r_vOut     <= '0;
      r_flushCnt <= '0;
      r_thresh   <= '0;
      r_outPixel <= '0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_adv) begin
        if (r_hIn == HW'(IMG_W - 1)) begin
          r_hIn <= '0;
          r_vIn <= (r_vIn == VW'(IMG_H - 1)) ? '0 : r_vIn + 1'b1;
        end else begin
          r_hIn <= r_hIn + 1'b1;
        end
      end

      if (w_emit) begin
        r_outValid <= 1'b1;
        r_outPixel <= w_border ? '0 : w_res;
        if (r_hOut == HW'(IMG_W - 1)) begin
          r_hOut <= '0;
          r_vOut <= (r_vOut == VW'(IMG_H - 1)) ? '0 : r_vOut + 1'b1;
        end else begin
          r_hOut <= r_hOut + 1'b1;
        end
      end else if (s_if.out_ready) begin
        r_outValid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_thresh   <= i_thresh;
            r_busy     <= 1'b1;
            r_hIn      <= '0;
            r_vIn      <= '0;
            r_hOut     <= '0;
            r_vOut     <= '0;
            r_flushCnt <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_adv && r_hIn == '0 && r_vIn == VW'(1)) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_adv && r_hIn == HW'(IMG_W - 1) && r_vIn == VW'(IMG_H - 1)) begin
            r_flushCnt <= '0;
            r_state    <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_flushStep) r_flushCnt <= r_flushCnt + 1'b1;
          if (r_flushCnt == FW'(FLUSH_N) && r_outValid && s_if.out_ready) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_if.in_ready  = w_inReady;
  assign s_if.out_pixel = r_outPixel;
  assign s_if.out_valid = r_outValid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream: five lockstep instances (modes 0-3 at OUT_W=7, mode 0 at OUT_W=6)
// share one 8x6 pixel stream; a software Sobel model fills the expected queue per frame.
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int NDUT = 5;

  typedef logic [NDUT-1:0][6:0] expVec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] thresh = '0;
  logic [3:0] inPixel = '0;
  logic       inValid = 1'b0;
  logic       outReady = 1'b1;
  logic       bpMode = 1'b0;

  logic [6:0]      outPix [NDUT];
  logic [NDUT-1:0] outValid;
  logic [NDUT-1:0] inReadyV;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] done;

  int      img [N];
  expVec_t expQ [$];
  int      checks = 0;
  int      failures = 0;
  int      cycleCnt = 0;
  int      outCount = 0;
  int      doneCount = 0;
  int      sawSat = 0;
  int      firstCycle = -1;
  int      acceptCycle = -2;
  bit      firstSeen = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt++;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int OW = (g == 4) ? 6 : 7;
    localparam int MD = (g == 4) ? 0 : g;
    sobel_stream_if #(.PIX_W(4), .OUT_W(OW)) bus ();
    assign bus.in_pixel  = inPixel;
    assign bus.in_valid  = inValid;
    assign bus.out_ready = outReady;
    assign outPix[g]     = 7'(bus.out_pixel);
    assign outValid[g]   = bus.out_valid;
    assign inReadyV[g]   = bus.in_ready;
    sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(4), .OUT_W(OW), .MODE(MD)) dut (
      .clock    (clock),
      .reset    (reset),
      .i_start  (start),
      .i_thresh (thresh),
      .s_if     (bus.slave),
      .o_busy   (busy[g]),
      .o_done   (done[g])
    );
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int px(input int h, input int v);
    return img[v * W + h];
  endfunction

  function automatic expVec_t model(input int k, input int th);
    expVec_t e;
    int h, v, gx, gy, ax, ay, s;
    e = '0;
    h = k % W;
    v = k / W;
    if (h == 0 || h == W - 1 || v == 0 || v == H - 1) return e;
    gx = (px(h+1, v-1) + 2 * px(h+1, v) + px(h+1, v+1)) - (px(h-1, v-1) + 2 * px(h-1, v) + px(h-1, v+1));
    gy = (px(h-1, v+1) + 2 * px(h, v+1) + px(h+1, v+1)) - (px(h-1, v-1) + 2 * px(h, v-1) + px(h+1, v-1));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = ax + ay;
    e[0] = 7'((s > 127) ? 127 : s);
    e[1] = 7'(ax);
    e[2] = 7'(ay);
    e[3] = (s > th) ? 7'd127 : 7'd0;
    e[4] = 7'((s > 63) ? 63 : s);
    return e;
  endfunction

  task automatic buildImage(input int pat, input int th);
    for (int v = 0; v < H; v++) begin
      for (int h = 0; h < W; h++) begin
        case (pat)
          0: img[v*W+h] = 9;
          1: img[v*W+h] = (h >= 4) ? 15 : 0;
          2: img[v*W+h] = (v >= 3) ? 15 : 0;
          3: img[v*W+h] = ((h + v) % 2 == 1) ? 15 : 0;
          default: img[v*W+h] = (h + v >= 7) ? 15 : 0;
        endcase
      end
    end
    expQ.delete();
    for (int k = 0; k < N; k++) expQ.push_back(model(k, th));
  endtask

  always @(posedge clock) begin
    #1;
    outReady = bpMode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (outValid[0] && !outReady) checkOutput("stallInReady", int'(inReadyV[0]), 0);
      if (outValid[0] && outReady) begin
        if (!firstSeen) begin
          firstSeen = 1'b1;
          firstCycle = cycleCnt;
        end
        if (expQ.size() == 0) begin
          checkOutput("extraOutput", outCount, -1);
        end else begin
          automatic expVec_t e = expQ.pop_front();
          for (int g = 0; g < NDUT; g++) begin
            checkOutput($sformatf("dut%0d_k%0d", g, outCount), int'(outPix[g]) + (outValid[g] ? 0 : 1000), int'(e[g]));
          end
        end
        if (outPix[4] == 7'd63) sawSat++;
        outCount++;
      end
      if (done[0]) doneCount++;
    end
  end

  task automatic applyStimulus(input int nIn, input bit bp, input bit midStart);
    int j = 0;
    int guard = 0;
    bit acc;
    while (j < nIn && guard < 4000) begin
      inValid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      inPixel = 4'(img[j]);
      start   = midStart && (j == 30);
      if (midStart && j == 30) thresh = '0;
      @(negedge clock);
      acc = inValid && inReadyV[0];
      @(posedge clock);
      #1;
      if (acc) begin
        if (j == W + 1) acceptCycle = cycleCnt;
        j++;
      end
      guard++;
    end
    inValid = 1'b0;
    start   = 1'b0;
    if (j < nIn) checkOutput("inputTimeout", j, nIn);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("busyAfterStart", int'(busy[0]), 1);
  endtask

  task automatic runFrame(input int pat, input bit bp, input int th, input bit midStart);
    buildImage(pat, th);
    outCount  = 0;
    doneCount = 0;
    firstSeen = 1'b0;
    bpMode    = bp;
    thresh    = 7'(th);
    pulseStart();
    applyStimulus(N, bp, midStart);
    for (int c = 0; c < 3000 && !done[0]; c++) @(negedge clock);
    if (!done[0]) checkOutput("doneTimeout", 0, 1);
    repeat (3) @(posedge clock);
    #1;
    bpMode = 1'b0;
    checkOutput($sformatf("outCount_p%0d", pat), outCount, N);
    checkOutput($sformatf("doneCount_p%0d", pat), doneCount, 1);
    checkOutput($sformatf("queueLeft_p%0d", pat), expQ.size(), 0);
    checkOutput("busyAfterDone", int'(busy[0]), 0);
    checkOutput("inReadyIdle", int'(inReadyV[0]), 0);
    if (!bp) checkOutput("firstLatency", firstCycle, acceptCycle);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_inReady"}, int'(inReadyV[0]), 0);
    checkOutput({tag, "_outValid"}, int'(outValid[0]), 0);
    checkOutput({tag, "_outPixel"}, int'(outPix[0]), 0);
    checkOutput({tag, "_busy"}, int'(busy[0]), 0);
    checkOutput({tag, "_done"}, int'(done[0]), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkResetState("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] flat frame");
    runFrame(0, 1'b0, 59, 1'b0);
    $display("[TB] vertical step, mid-frame start and thresh change");
    runFrame(1, 1'b0, 61, 1'b1);
    $display("[TB] horizontal step");
    runFrame(2, 1'b0, 59, 1'b0);
    $display("[TB] vertical step with backpressure");
    runFrame(1, 1'b1, 59, 1'b0);

    $display("[TB] reset mid-frame");
    buildImage(1, 59);
    outCount = 0;
    thresh = 7'd59;
    pulseStart();
    applyStimulus(20, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkResetState("midReset");
    reset = 1'b0;
    expQ.delete();
    @(posedge clock);
    #1;
    runFrame(0, 1'b0, 59, 1'b0);

    $display("[TB] checkerboard");
    runFrame(3, 1'b0, 59, 1'b0);
    $display("[TB] diagonal saturation");
    sawSat = 0;
    runFrame(4, 1'b1, 59, 1'b0);
    checkOutput("sawSaturation", int'(sawSat > 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
